xip_flash_responder: RTL and testbench

XIP_FLASH_RESPONDER -- requirements
Module: xip_flash_responder

---
 rtl/xip_flash_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_xip_flash_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/xip_flash_responder.sv
// xip_flash_responder: SPI-flash style read responder (execute-in-place).
// Accepts READ (0x03) and, when XIP_FLASH_RESPONDER_FAST_READ_EN is defined,
// FAST READ (0x0B, 8 dummy clocks). Other commands raise a cmdError pulse.
// SPI mode 0; every SPI input is resynchronised into io_mainClk.
// Data is streamed from a byte-wide backing memory with a one-byte prefetch
// buffer, so the bytes come out back to back.
module xip_flash_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  io_mainClk,
  input  logic                  io_resetn,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_ss,
  input  logic                  io_spi_mosi,
  output logic                  io_spi_miso,
  output logic                  io_spi_misoEnable,
  output logic [ADDR_WIDTH-1:0] io_mem_addr,
  output logic                  io_mem_rdEn,
  input  logic [7:0]            io_mem_rdData,
  output logic                  io_cmdError
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
    , ST_DUMMY = 3'd3
`endif
  } state_t;

  // synchronizer and edge-detect flops
  logic sclk_meta, sclk_sync, sclk_prev;
  logic ss_meta, ss_sync;
  logic mosi_meta, mosi_sync;
  logic [1:0] settle_cnt;
  logic settle_done;
  logic sclk_rise, sclk_fall;

  // transaction state
  state_t state;
  logic armed;
  logic [4:0] bit_cnt;
  logic [6:0] cmd_sr;
  logic [7:0] cmd_byte;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [7:0] shift_out;
  logic [7:0] hold_buf;
  logic rd_dest_shift;
  logic rd_pend;
  logic rd_pend_shift;
  logic miso;
  logic miso_en;
  logic rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic cmd_error;
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
  logic is_fast;
`endif

  assign sclk_rise   = sclk_sync & ~sclk_prev;
  assign sclk_fall   = ~sclk_sync & sclk_prev;
  assign settle_done = (settle_cnt == 2'd2);
  assign cmd_byte    = {cmd_sr, mosi_sync};
  assign addr_next   = {addr_sr[ADDR_WIDTH-2:0], mosi_sync};

  assign io_spi_miso       = miso;
  assign io_spi_misoEnable = miso_en;
  assign io_mem_addr       = mem_addr;
  assign io_mem_rdEn       = rd_en;
  assign io_cmdError       = cmd_error;

  // Two-flop synchronizers plus a settle counter that tells when ss_sync reflects the pin
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_prev  <= 1'b0;
      ss_meta    <= 1'b1;
      ss_sync    <= 1'b1;
      mosi_meta  <= 1'b0;
      mosi_sync  <= 1'b0;
      settle_cnt <= 2'd0;
    end else begin
      sclk_meta <= io_spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      ss_meta   <= io_spi_ss;
      ss_sync   <= ss_meta;
      mosi_meta <= io_spi_mosi;
      mosi_sync <= mosi_meta;
      if (!settle_done) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else begin
        settle_cnt <= settle_cnt;
      end
    end
  end

  // Protocol FSM with registered outputs, memory read issue and prefetch capture
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      state         <= ST_IDLE;
      armed         <= 1'b0;
      bit_cnt       <= 5'd0;
      cmd_sr        <= 7'd0;
      addr_sr       <= '0;
      shift_out     <= 8'd0;
      hold_buf      <= 8'd0;
      rd_dest_shift <= 1'b0;
      rd_pend       <= 1'b0;
      rd_pend_shift <= 1'b0;
      miso          <= 1'b0;
      miso_en       <= 1'b0;
      rd_en         <= 1'b0;
      mem_addr      <= '0;
      cmd_error     <= 1'b0;
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
      is_fast       <= 1'b0;
`endif
    end else if (ss_sync) begin
      // Deselect wins over any coincident sclk edge; partial state is dropped.
      // Arming waits until the synchronizer shows a real high after reset.
      state         <= ST_IDLE;
      armed         <= armed | settle_done;
      bit_cnt       <= 5'd0;
      shift_out     <= 8'd0;
      hold_buf      <= 8'd0;
      rd_dest_shift <= 1'b0;
      rd_pend       <= 1'b0;
      rd_pend_shift <= 1'b0;
      miso          <= 1'b0;
      miso_en       <= 1'b0;
      rd_en         <= 1'b0;
      cmd_error     <= 1'b0;
    end else begin
      rd_en         <= 1'b0;
      cmd_error     <= 1'b0;
      rd_pend       <= rd_en;
      rd_pend_shift <= rd_dest_shift;
      case (state)
        ST_IDLE: begin
          bit_cnt <= 5'd0;
          if (armed) begin
            state <= ST_CMD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_sr <= cmd_byte[6:0];
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              if (cmd_byte == 8'h03) begin
                state <= ST_ADDR;
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
                is_fast <= 1'b0;
              end else if (cmd_byte == 8'h0B) begin
                state   <= ST_ADDR;
                is_fast <= 1'b1;
`endif
              end else begin
                state     <= ST_IGNORE;
                cmd_error <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            // Bits above ADDR_WIDTH fall off the top of the shift register.
            addr_sr <= addr_next;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= 5'd0;
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
              if (is_fast) begin
                state <= ST_DUMMY;
              end else begin
                state         <= ST_DATA;
                rd_en         <= 1'b1;
                mem_addr      <= addr_next;
                rd_dest_shift <= 1'b1;
              end
`else
              state         <= ST_DATA;
              rd_en         <= 1'b1;
              mem_addr      <= addr_next;
              rd_dest_shift <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
        ST_DUMMY: begin
          if (sclk_rise) begin
            if (bit_cnt == 5'd7) begin
              bit_cnt       <= 5'd0;
              state         <= ST_DATA;
              rd_en         <= 1'b1;
              mem_addr      <= addr_sr;
              rd_dest_shift <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
`endif
        ST_DATA: begin
          if (sclk_fall) begin
            miso    <= shift_out[7];
            miso_en <= 1'b1;
            if (bit_cnt[2:0] == 3'd7) begin
              // Last bit of the byte leaves now: swap in the prefetched byte
              // and start fetching the one after it.
              bit_cnt       <= 5'd0;
              shift_out     <= hold_buf;
              rd_en         <= 1'b1;
              mem_addr      <= mem_addr + ADDR_ONE;
              rd_dest_shift <= 1'b0;
            end else begin
              bit_cnt   <= bit_cnt + 5'd1;
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: begin
          state <= ST_IGNORE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      // Read data arrives one cycle after the strobe; the first read of a
      // burst fills the shift register and immediately prefetches the next.
      if (rd_pend) begin
        if (rd_pend_shift) begin
          shift_out     <= io_mem_rdData;
          rd_en         <= 1'b1;
          mem_addr      <= mem_addr + ADDR_ONE;
          rd_dest_shift <= 1'b0;
        end else begin
          hold_buf <= io_mem_rdData;
        end
      end
    end
  end

endmodule

// File: tb/tb_xip_flash_responder.sv
// Directed testbench for xip_flash_responder (ADDR_WIDTH = 12).
// Build with XIP_FLASH_RESPONDER_FAST_READ_EN defined to exercise FAST READ.
module tb_xip_flash_responder;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic resetn;
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;
  logic miso_en;
  logic [AW-1:0] mem_addr;
  logic rd_en;
  logic [7:0] rd_data = 8'd0;
  logic cmd_error;

  logic [7:0] mem [0:4095];

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int en_cnt = 0;

  xip_flash_responder #(.ADDR_WIDTH(AW)) dut (
    .io_mainClk       (clk),
    .io_resetn        (resetn),
    .io_spi_sclk      (sclk),
    .io_spi_ss        (ss),
    .io_spi_mosi      (mosi),
    .io_spi_miso      (miso),
    .io_spi_misoEnable(miso_en),
    .io_mem_addr      (mem_addr),
    .io_mem_rdEn      (rd_en),
    .io_mem_rdData    (rd_data),
    .io_cmdError      (cmd_error)
  );

  always #5 clk = ~clk;

  // backing memory: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[mem_addr];
  end

  // event counters for cmdError pulses and misoEnable cycles
  always @(negedge clk) begin
    if (cmd_error) err_cnt = err_cnt + 1;
    if (miso_en) en_cnt = en_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    #50 sclk = 1'b1;
    r = miso;
    #50 sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] v;
    logic r;
    v = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      v[i] = r;
    end
    rx = v;
  endtask

  task automatic begin_txn();
    ss = 1'b0;
    #100;
  endtask

  task automatic end_txn();
    #50 ss = 1'b1;
    #200;
  endtask

  task automatic send_read(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(cmd, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
  endtask

  initial begin
    logic [7:0] rx;
    logic r;
    int e0;
    int n0;

    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h010] = 8'hA5;
    mem[12'h011] = 8'h3C;
    mem[12'h012] = 8'hFF;
    mem[12'h013] = 8'h00;
    mem[12'hFFF] = 8'h5B;
    mem[12'h000] = 8'hC3;
    mem[12'h004] = 8'h96;
    mem[12'h007] = 8'h4E;
    mem[12'h020] = 8'h71;
    mem[12'h100] = 8'h12;
    mem[12'h101] = 8'hE7;

    resetn = 1'b0;
    ss = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    #100;
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_miso_en", 32'(miso_en), 32'd0);
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_cmd_error", 32'(cmd_error), 32'd0);
    resetn = 1'b1;
    #100;

    // READ 0x000010, four bytes back to back
    begin_txn();
    send_read(8'h03, 24'h000010);
    spi_byte(8'h00, rx); check("read_b0", 32'(rx), 32'hA5);
    spi_byte(8'h00, rx); check("read_b1", 32'(rx), 32'h3C);
    spi_byte(8'h00, rx); check("read_b2", 32'(rx), 32'hFF);
    check("read_en_on", 32'(miso_en), 32'd1);
    spi_byte(8'h00, rx); check("read_b3", 32'(rx), 32'h00);
    end_txn();
    check("idle_en_off", 32'(miso_en), 32'd0);
    check("idle_miso_low", 32'(miso), 32'd0);

    // READ 0xFFFFFF: upper bits dropped, wrap to 0
    begin_txn();
    send_read(8'h03, 24'hFFFFFF);
    spi_byte(8'h00, rx); check("wrap_b0", 32'(rx), 32'h5B);
    spi_byte(8'h00, rx); check("wrap_b1", 32'(rx), 32'hC3);
    end_txn();

    // unsupported 0x9F
    e0 = err_cnt;
    n0 = en_cnt;
    begin_txn();
    spi_byte(8'h9F, rx);
    for (int k = 0; k < 4; k++) spi_byte(8'h00, rx);
    end_txn();
    check("bad_cmd_err", 32'(err_cnt - e0), 32'd1);
    check("bad_cmd_no_en", 32'(en_cnt - n0), 32'd0);
    begin_txn();
    send_read(8'h03, 24'h000000);
    spi_byte(8'h00, rx); check("after_bad_b0", 32'(rx), 32'hC3);
    end_txn();

    // FAST READ 0x000020
    e0 = err_cnt;
    n0 = en_cnt;
    begin_txn();
    send_read(8'h0B, 24'h000020);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    end_txn();
`ifdef XIP_FLASH_RESPONDER_FAST_READ_EN
    check("fast_b0", 32'(rx), 32'h71);
    check("fast_no_err", 32'(err_cnt - e0), 32'd0);
`else
    check("fast_off_err", 32'(err_cnt - e0), 32'd1);
    check("fast_off_no_en", 32'(en_cnt - n0), 32'd0);
`endif

    // abort after 13 address bits, then a clean READ 0x000004
    begin_txn();
    spi_byte(8'h03, rx);
    for (int k = 0; k < 13; k++) spi_bit(1'b1, r);
    end_txn();
    begin_txn();
    send_read(8'h03, 24'h000004);
    spi_byte(8'h00, rx); check("partial_then_b0", 32'(rx), 32'h96);
    end_txn();

    // reset pulsed mid-DATA
    begin_txn();
    send_read(8'h03, 24'h000100);
    spi_byte(8'h00, rx); check("pre_reset_b0", 32'(rx), 32'h12);
    for (int k = 0; k < 3; k++) spi_bit(1'b0, r);
    check("pre_reset_en", 32'(miso_en), 32'd1);
    resetn = 1'b0;
    #10;
    check("mid_reset_en", 32'(miso_en), 32'd0);
    check("mid_reset_miso", 32'(miso), 32'd0);
    #10 resetn = 1'b1;
    #80;
    // ss still low: no fresh falling edge, so no response
    n0 = en_cnt;
    send_read(8'h03, 24'h000000);
    spi_byte(8'h00, rx);
    check("no_fresh_ss_no_en", 32'(en_cnt - n0), 32'd0);
    end_txn();
    begin_txn();
    send_read(8'h03, 24'h000007);
    spi_byte(8'h00, rx); check("recover_b0", 32'(rx), 32'h4E);
    end_txn();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
